// File: rtl/serial_seq_gen.sv
// Bus-mapped serial-data sequencer: decodes a read window, executes
// LOAD/STEP/BURST/STOP commands from the address bits and steps a
// parametrised Fibonacci LFSR whose msb drives the serial data pin.
module serial_seq_gen #(
  parameter int                WIDTH     = 6,
  parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(6'b110000),
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] SEL_MASK  = ADDR_W'(14'h3000),
  parameter logic [ADDR_W-1:0] SEL_MATCH = ADDR_W'(14'h1000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ba,
  input  logic              sser,
  input  logic              br_w,
  output logic              sd_out,
  output logic              sd_oe,
  output logic [WIDTH-1:0]  state_q,
  output logic              busy,
  output logic              done,
  output logic [7:0]        bit_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  localparam logic [3:0] CMD_LOAD  = 4'h1;
  localparam logic [3:0] CMD_STEP  = 4'h2;
  localparam logic [3:0] CMD_BURST = 4'h3;
  localparam logic [3:0] CMD_STOP  = 4'h4;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       rem_q, rem_d;
  logic             done_q, done_d;

  logic             acc;
  logic [3:0]       cmd;
  logic [3:0]       arg;
  logic [WIDTH-1:0] tap_terms;
  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             is_load, is_step, is_burst, is_stop;

  // Window decode is combinational so the pin enable tracks the bus
  // immediately, even while reset is asserted.
  assign acc   = ~sser & br_w & ((ba & SEL_MASK) == SEL_MATCH);
  assign sd_oe = acc;
  assign cmd   = ba[7:4];
  assign arg   = ba[3:0];

  assign is_load  = acc && (cmd == CMD_LOAD);
  assign is_step  = acc && (cmd == CMD_STEP);
  assign is_burst = acc && (cmd == CMD_BURST);
  assign is_stop  = acc && (cmd == CMD_STOP);

  // Feedback is the parity of the tapped state bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tap_terms[gi] = TAPS[gi] & state_q[gi];
  end
  assign fb       = ^tap_terms;
  assign step_val = {state_q[WIDTH-2:0], fb};

  // A zero argument would lock the LFSR, so it loads 1 instead.
  assign load_val = (arg == 4'h0) ? WIDTH'(1) : {{(WIDTH-4){1'b0}}, arg};

  assign sd_out  = state_q[WIDTH-1];
  assign busy    = (fsm_q == RUN);
  assign done    = done_q;
  assign bit_cnt = cnt_q;

  // Next-state logic: LOAD beats STOP beats the burst step beats idle commands.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (is_load) begin
      state_d = load_val;
      cnt_d   = 8'd0;
      rem_d   = 5'd0;
      fsm_d   = IDLE;
    end else if (is_stop) begin
      rem_d = 5'd0;
      fsm_d = IDLE;
    end else if (fsm_q == RUN) begin
      state_d = step_val;
      cnt_d   = cnt_q + 8'd1;
      rem_d   = rem_q - 5'd1;
      if (rem_q == 5'd1) begin
        fsm_d  = IDLE;
        done_d = 1'b1;
      end
    end else if (is_step) begin
      state_d = step_val;
      cnt_d   = cnt_q + 8'd1;
    end else if (is_burst) begin
      rem_d = {1'b0, arg} + 5'd1;
      fsm_d = RUN;
    end
  end

  // State register with synchronous reset to the non-zero seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= WIDTH'(1);
      cnt_q   <= 8'd0;
      rem_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_seq_gen.sv
// Bench for serial_seq_gen: two instances (6-bit default, 8-bit taps B8)
// share the bus and are compared every cycle against a behavioural model.
module tb_serial_seq_gen;

  logic        clk = 1'b0;
  logic        rst, sser, br_w;
  logic [13:0] ba;
  logic        sd_out_a, sd_oe_a, busy_a, done_a;
  logic        sd_out_b, sd_oe_b, busy_b, done_b;
  logic [5:0]  state_a;
  logic [7:0]  state_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  int wm[2] = '{6, 8};
  int tm[2] = '{'h30, 'hB8};
  int m_state[2], m_cnt[2], m_busy[2], m_done[2], m_rem[2];

  always #5 clk = ~clk;

  serial_seq_gen u_a (
    .clk(clk), .rst(rst), .ba(ba), .sser(sser), .br_w(br_w),
    .sd_out(sd_out_a), .sd_oe(sd_oe_a), .state_q(state_a),
    .busy(busy_a), .done(done_a), .bit_cnt(cnt_a)
  );

  serial_seq_gen #(.WIDTH(8), .TAPS(8'hB8)) u_b (
    .clk(clk), .rst(rst), .ba(ba), .sser(sser), .br_w(br_w),
    .sd_out(sd_out_b), .sd_oe(sd_oe_b), .state_q(state_b),
    .busy(busy_b), .done(done_b), .bit_cnt(cnt_b)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit acc_model();
    return !sser && br_w && ((ba & 14'h3000) == 14'h1000);
  endfunction

  function automatic int lfsr_next(int s, int w, int taps);
    int fb;
    fb = $countones(s & taps) & 1;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  task automatic advance(int i);
    m_state[i] = lfsr_next(m_state[i], wm[i], tm[i]);
    m_cnt[i]   = (m_cnt[i] + 1) % 256;
  endtask

  // Behaviour at one clock edge, from the command priority rules.
  task automatic model_edge();
    bit a;
    int cmd, arg;
    a   = acc_model();
    cmd = int'(ba[7:4]);
    arg = int'(ba[3:0]);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (rst) begin
        m_state[i] = 1; m_cnt[i] = 0; m_busy[i] = 0; m_rem[i] = 0;
      end else if (a && cmd == 1) begin
        m_state[i] = (arg == 0) ? 1 : arg;
        m_cnt[i] = 0; m_busy[i] = 0; m_rem[i] = 0;
      end else if (a && cmd == 4) begin
        m_busy[i] = 0;
      end else if (m_busy[i] != 0) begin
        advance(i);
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end else if (a && cmd == 2) begin
        advance(i);
      end else if (a && cmd == 3) begin
        m_busy[i] = 1;
        m_rem[i]  = arg + 1;
      end
    end
  endtask

  task automatic tick();
    #2;
    check("sd_oe_a", 32'(sd_oe_a), 32'(acc_model()));
    check("sd_oe_b", 32'(sd_oe_b), 32'(acc_model()));
    @(posedge clk);
    model_edge();
    #1;
    check("state_a", 32'(state_a), m_state[0]);
    check("sd_out_a", 32'(sd_out_a), (m_state[0] >> 5) & 1);
    check("busy_a", 32'(busy_a), m_busy[0]);
    check("done_a", 32'(done_a), m_done[0]);
    check("cnt_a", 32'(cnt_a), m_cnt[0]);
    check("state_b", 32'(state_b), m_state[1]);
    check("sd_out_b", 32'(sd_out_b), (m_state[1] >> 7) & 1);
    check("busy_b", 32'(busy_b), m_busy[1]);
    check("done_b", 32'(done_b), m_done[1]);
    check("cnt_b", 32'(cnt_b), m_cnt[1]);
  endtask

  task automatic set_bus(bit r, bit s, bit b, logic [13:0] addr);
    rst = r; sser = s; br_w = b; ba = addr;
  endtask

  task automatic set_idle();
    set_bus(1'b0, 1'b1, 1'b0, 14'h0000);
  endtask

  task automatic cmd_op(int cmd, int arg);
    set_bus(1'b0, 1'b0, 1'b1, 14'h1000 | 14'(cmd << 4) | 14'(arg));
    tick();
    set_idle();
  endtask

  initial begin
    int exp_seq[6] = '{'h02, 'h04, 'h08, 'h10, 'h21, 'h03};
    int exp_pre[6] = '{0, 0, 0, 0, 0, 1};
    int ret_a, ret_b, guard, waits, left;
    int rc, rcmd, rarg;
    logic [13:0] raddr;

    for (int i = 0; i < 2; i++) begin
      m_state[i] = 1; m_cnt[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_rem[i] = 0;
    end

    // Reset for two cycles, then idle.
    set_bus(1'b1, 1'b1, 1'b0, 14'h0000);
    tick();
    tick();
    check("rst_state", 32'(state_a), 32'h01);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    set_idle();
    tick();
    check("idle_oe", 32'(sd_oe_a), 32'h0);

    // Decode and lock-up guard on LOAD 0.
    cmd_op(1, 5);
    check("load5", 32'(state_a), 32'h05);
    set_bus(1'b0, 1'b0, 1'b1, 14'h1010);
    #2;
    check("dec_oe", 32'(sd_oe_a), 32'h1);
    tick();
    set_idle();
    check("load0_guard", 32'(state_a), 32'h01);
    set_bus(1'b0, 1'b0, 1'b0, 14'h1017);
    tick();
    set_bus(1'b0, 1'b1, 1'b1, 14'h1017);
    tick();
    set_bus(1'b0, 1'b0, 1'b1, 14'h3017);
    tick();
    set_idle();
    check("no_decode", 32'(state_a), 32'h01);

    // Single steps from seed 1.
    cmd_op(1, 1);
    for (int k = 0; k < 6; k++) begin
      check("sd_pre", 32'(sd_out_a), 32'(exp_pre[k]));
      cmd_op(2, 0);
      check("step_seq", 32'(state_a), 32'(exp_seq[k]));
    end
    check("step_cnt", 32'(cnt_a), 32'd6);

    // Burst of 4 with an ignored STEP inside it.
    cmd_op(1, 1);
    cmd_op(3, 3);
    check("burst_busy0", 32'(busy_a), 32'h1);
    tick();
    check("burst_busy1", 32'(busy_a), 32'h1);
    cmd_op(2, 0);
    check("burst_busy2", 32'(busy_a), 32'h1);
    tick();
    check("burst_busy3", 32'(busy_a), 32'h1);
    tick();
    check("burst_end_busy", 32'(busy_a), 32'h0);
    check("burst_done", 32'(done_a), 32'h1);
    check("burst_state", 32'(state_a), 32'h10);
    check("burst_cnt", 32'(cnt_a), 32'd4);
    tick();
    check("done_pulse", 32'(done_a), 32'h0);

    // LOAD preempts a running burst.
    cmd_op(1, 1);
    cmd_op(3, 15);
    tick();
    tick();
    cmd_op(1, 5);
    check("pre_load_state", 32'(state_a), 32'h05);
    check("pre_load_busy", 32'(busy_a), 32'h0);
    tick();
    check("pre_load_done", 32'(done_a), 32'h0);

    // STOP holds state, no done.
    cmd_op(3, 15);
    tick();
    cmd_op(4, 0);
    check("stop_busy", 32'(busy_a), 32'h0);
    tick();
    tick();

    // STOP and LOAD landing on the final burst step.
    cmd_op(3, 0);
    cmd_op(4, 0);
    check("stop_final_done", 32'(done_a), 32'h0);
    tick();
    cmd_op(3, 0);
    cmd_op(1, 3);
    check("load_final_done", 32'(done_a), 32'h0);
    check("load_final_state", 32'(state_a), 32'h03);
    tick();

    // Reset mid-burst.
    cmd_op(3, 7);
    tick();
    tick();
    set_bus(1'b1, 1'b1, 1'b0, 14'h0000);
    tick();
    check("rst_mid_state", 32'(state_a), 32'h01);
    check("rst_mid_busy", 32'(busy_a), 32'h0);
    set_idle();
    tick();
    check("rst_mid_done", 32'(done_a), 32'h0);

    // Full period via repeated bursts.
    cmd_op(1, 1);
    ret_a = 0;
    ret_b = 0;
    guard = 0;
    while (m_cnt[0] < 255 && guard < 40) begin
      left = 255 - m_cnt[0];
      cmd_op(3, (left > 16) ? 15 : left - 1);
      waits = 0;
      while (m_busy[0] != 0 && waits < 20) begin
        tick();
        waits++;
        check("nonzero_a", 32'(state_a != 6'h00), 32'h1);
        check("nonzero_b", 32'(state_b != 8'h00), 32'h1);
        if (ret_a == 0 && state_a == 6'h01) ret_a = m_cnt[0];
        if (ret_b == 0 && state_b == 8'h01) ret_b = m_cnt[1];
      end
      if (m_busy[0] != 0) begin
        n_errors++;
        $error("FAIL burst_timeout: observed busy after %0d cycles expected idle", waits);
      end
      guard++;
    end
    check("period_a", 32'(ret_a), 32'd63);
    check("period_b", 32'(ret_b), 32'd255);
    check("period_cnt", 32'(cnt_a), 32'd255);
    cmd_op(2, 0);
    check("cnt_wrap", 32'(cnt_a), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rc   = $urandom_range(0, 99);
      rcmd = $urandom_range(0, 6);
      rarg = $urandom_range(0, 15);
      if ($urandom_range(0, 9) != 0)
        raddr = 14'h1000 | 14'($urandom_range(0, 15) << 8) | 14'(rcmd << 4) | 14'(rarg);
      else
        raddr = 14'($urandom_range(0, 16383));
      set_bus(rc < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, raddr);
      tick();
    end
    set_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
